led_fade_pwm: RTL and testbench
===============================

Name: led_fade_pwm

Overview:
- Downstream LED output stage. Consumes the 10 us tick strobe from the shared prescaler and drives an active-low LED.
- Produces a repeating "breathe" pattern: fade in, hold, fade out, off.
- Brightness ramps linearly in fixed steps. It is rendered by a free-running PWM counter clocked at clk (24 MHz PLL output).
- Sits between the timer/prescaler logic and the LED pad.

Parameters:
- PWM_BITS, 7, brightness and PWM counter width; PWM period is 2^PWM_BITS clk cycles; BMAX = 2^PWM_BITS-1.
- STEP_TICKS, 100, tick strobes per ramp step (default 1 ms per step); must be >= 1.
- HOLD_STEPS, 150, steps spent at BMAX in HOLD; must be >= 1.
- OFF_STEPS, 600, steps spent dark in OFF before the next cycle; must be >= 1.

Ports:
- clk  input  1  system clock (PLL output, 24 MHz).
- reset  input  1  asynchronous, active-high reset (driven from ~pll_locked).
- tick  input  1  one-clk-wide strobe every 10 us, synchronous to clk.
- enable  input  1  level; high allows cycles to start and continue.
- led_n  output  1  LED drive, active low.
- busy  output  1  high in RISE, HOLD or FALL.
- brightness  output  PWM_BITS  current brightness level.
- cycle_done  output  1  one-clk pulse when an OFF period completes.

Behaviour:
- Reset: all registers clear asynchronously on reset.
  - Reset values: state=OFF, brightness=0, tick_cnt=0, phase_cnt=0, pwm_cnt=0.
  - Outputs: led_n=1, busy=0, cycle_done=0.
  - Reset mid-ramp returns to OFF with the LED dark in the same cycle.
- Step strobe:
  - tick_cnt counts tick pulses, 0..STEP_TICKS-1.
  - step is high in a cycle with tick=1 and tick_cnt=STEP_TICKS-1; tick_cnt then wraps to 0.
  - tick_cnt is held at 0 while state=OFF and enable=0.
- State machine (2-bit encoding, OFF=0, RISE=1, HOLD=2, FALL=3). All transitions occur on the clk edge of a step unless noted.
  - OFF:
    - enable=0: stay in OFF; phase_cnt held 0.
    - enable=1: phase_cnt counts steps. On the step where phase_cnt=OFF_STEPS-1, set phase_cnt=0, pulse cycle_done and go to RISE.
  - RISE: brightness+1 per step. The step that makes brightness=BMAX moves to HOLD with phase_cnt=0.
  - HOLD: phase_cnt counts steps. On phase_cnt=HOLD_STEPS-1, go to FALL.
  - FALL: brightness-1 per step. The step that makes brightness=0 moves to OFF with phase_cnt=0.
  - enable=0 while in RISE or HOLD: go to FALL on the next clk edge, no step required. Brightness is kept and phase_cnt is cleared.
  - enable=0 in FALL: no effect; the fade completes.
  - enable=0 then 1 again during FALL: no effect; the block still completes OFF before the next RISE.
- Arithmetic:
  - brightness saturates: never increments above BMAX and never decrements below 0.
  - Counters are unsigned and wrap only at the points defined above.
- PWM:
  - pwm_cnt increments every clk and wraps from BMAX to 0.
  - led_n is registered: led_n <= ~(pwm_cnt < brightness), giving one clk of latency from pwm_cnt/brightness.
  - brightness=0 gives led_n constantly 1.
  - brightness=BMAX gives led_n=0 for BMAX of every 2^PWM_BITS cycles.
  - pwm_cnt free-runs independent of state.
- busy and cycle_done are registered, decoded from the next state.
- Simultaneous events: in a cycle with enable falling and step, the forced FALL takes priority over the step; brightness does not change that cycle.

Test Plan:
Benches use PWM_BITS=3, STEP_TICKS=2, HOLD_STEPS=3, OFF_STEPS=4, with tick every 4 clk.
- Reset held with enable=1 -> led_n=1, brightness=0, busy=0, cycle_done=0. After release, the first cycle_done pulse occurs after 8 ticks (4 steps), then state=RISE.
- Full cycle -> brightness steps 0..7, one step per 2 ticks. The step reaching 7 enters HOLD, which lasts 3 steps. FALL steps 7..0, then OFF lasts 4 steps. Check busy high exactly from RISE entry to OFF entry.
- PWM duty at brightness=3 -> over any 8 consecutive clk, led_n=0 for exactly 3 cycles. Confirm one clk latency relative to pwm_cnt<3.
- enable dropped at brightness=5 in RISE -> next clk state=FALL, brightness stays 5. It then decrements to 0 over 5 steps, enters OFF and stays there with tick_cnt=0, and no cycle_done is produced.
- enable re-raised mid-FALL -> the fall completes, then 4 OFF steps run, cycle_done pulses, and RISE begins.
- reset asserted asynchronously during HOLD -> led_n=1 and state=OFF before the next clk edge, with all counters 0.

Source files
------------

// File: rtl/led_fade_pwm.sv
// LED "breathe" driver: fade in, hold at full brightness, fade out, stay dark, repeat.
//
// A prescaled tick strobe is divided down to ramp steps. A four-state machine
// (OFF, RISE, HOLD, FALL) walks the brightness level up and down one step at a time.
// A free-running PWM counter renders the brightness onto an active-low LED pin.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   tick       in   one-clk strobe from the shared prescaler
//   enable     in   level; high lets a breathe cycle start and continue
//   led_n      out  LED drive, active low, registered
//   busy       out  high while in RISE, HOLD or FALL (registered)
//   brightness out  current brightness level, PWM_BITS wide
//   cycle_done out  one-clk pulse when an OFF period completes (registered)

module led_fade_pwm #(
    parameter int unsigned PWM_BITS   = 7,
    parameter int unsigned STEP_TICKS = 100,
    parameter int unsigned HOLD_STEPS = 150,
    parameter int unsigned OFF_STEPS  = 600
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                enable,
    output logic                led_n,
    output logic                busy,
    output logic [PWM_BITS-1:0] brightness,
    output logic                cycle_done
);

    // Counter widths; a single bit is kept when a count range collapses to one value.
    localparam int unsigned TICK_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int unsigned PHASE_MAX = (HOLD_STEPS > OFF_STEPS) ? HOLD_STEPS : OFF_STEPS;
    localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(STEP_TICKS - 1);
    localparam logic [PHASE_W-1:0]  HOLD_LAST = PHASE_W'(HOLD_STEPS - 1);
    localparam logic [PHASE_W-1:0]  OFF_LAST  = PHASE_W'(OFF_STEPS - 1);
    localparam logic [PHASE_W-1:0]  PHASE_ONE = PHASE_W'(1);
    localparam logic [TICK_W-1:0]   TICK_ONE  = TICK_W'(1);
    localparam logic [PWM_BITS-1:0] B_ZERO    = '0;
    localparam logic [PWM_BITS-1:0] B_ONE     = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] B_MAX     = '1;
    localparam logic [PWM_BITS-1:0] B_MAX_M1  = B_MAX - B_ONE;

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StRise = 2'd1,
        StHold = 2'd2,
        StFall = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [PHASE_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [PWM_BITS-1:0]  bright_q, bright_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q;
    logic                 led_n_q;
    logic                 busy_q;
    logic                 done_q, done_d;
    logic                 step;

    // One ramp step every STEP_TICKS tick strobes.
    assign step = tick && (tick_cnt_q == TICK_LAST);

    // Tick prescaler: parked at zero while idle so an enabled OFF period always
    // starts from a full step.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if ((state_q == StOff) && !enable) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_ONE;
        end
    end

    // Breathe state machine, next-state and datapath.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        bright_d    = bright_q;
        done_d      = 1'b0;

        unique case (state_q)
            StOff: begin
                if (!enable) begin
                    phase_cnt_d = '0;
                end else if (step) begin
                    if (phase_cnt_q == OFF_LAST) begin
                        phase_cnt_d = '0;
                        done_d      = 1'b1;
                        state_d     = StRise;
                    end else begin
                        phase_cnt_d = phase_cnt_q + PHASE_ONE;
                    end
                end
            end

            StRise: begin
                // Losing enable wins over a coincident step: brightness is frozen.
                if (!enable) begin
                    state_d     = StFall;
                    phase_cnt_d = '0;
                end else if (step) begin
                    if (bright_q != B_MAX) begin
                        bright_d = bright_q + B_ONE;
                    end
                    if (bright_q >= B_MAX_M1) begin
                        state_d     = StHold;
                        phase_cnt_d = '0;
                    end
                end
            end

            StHold: begin
                if (!enable) begin
                    state_d     = StFall;
                    phase_cnt_d = '0;
                end else if (step) begin
                    if (phase_cnt_q == HOLD_LAST) begin
                        state_d     = StFall;
                        phase_cnt_d = '0;
                    end else begin
                        phase_cnt_d = phase_cnt_q + PHASE_ONE;
                    end
                end
            end

            StFall: begin
                // enable is ignored here: a fade-out always runs to dark and then OFF.
                if (step) begin
                    if (bright_q != B_ZERO) begin
                        bright_d = bright_q - B_ONE;
                    end
                    if (bright_q <= B_ONE) begin
                        state_d     = StOff;
                        phase_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = StOff;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StOff;
            tick_cnt_q  <= '0;
            phase_cnt_q <= '0;
            bright_q    <= '0;
            pwm_cnt_q   <= '0;
            led_n_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            bright_q    <= bright_d;
            // Free-running; wraps from B_MAX to zero on its own.
            pwm_cnt_q   <= pwm_cnt_q + B_ONE;
            // Comparator output is registered, so the pin lags pwm_cnt/brightness by one clk.
            led_n_q     <= ~(pwm_cnt_q < bright_q);
            busy_q      <= (state_d != StOff);
            done_q      <= done_d;
        end
    end

    assign led_n      = led_n_q;
    assign busy       = busy_q;
    assign brightness = bright_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with PWM_BITS=3, STEP_TICKS=2, HOLD_STEPS=3,
// OFF_STEPS=4 and a tick strobe every 4 clk.

module tb_led_fade_pwm;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       enable;
    logic       led_n;
    logic       busy;
    logic [2:0] brightness;
    logic       cycle_done;

    int         n_cmp;
    int         n_fail;
    int         tick_total;
    int         tphase;
    logic [2:0] pwm_m;

    led_fade_pwm #(
        .PWM_BITS  (3),
        .STEP_TICKS(2),
        .HOLD_STEPS(3),
        .OFF_STEPS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .enable    (enable),
        .led_n     (led_n),
        .busy      (busy),
        .brightness(brightness),
        .cycle_done(cycle_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick strobe: high on every 4th clk after reset is released.
    initial begin
        tick   = 1'b0;
        tphase = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                tphase = 0;
                tick   = 1'b0;
            end else begin
                tphase = (tphase + 1) % 4;
                tick   = (tphase == 0);
            end
        end
    end

    // Count of tick strobes the DUT has seen at a rising edge.
    always @(posedge clk) begin
        if (!reset && tick) tick_total <= tick_total + 1;
    end

    // Reference PWM counter, reset together with the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) pwm_m <= 3'd0;
        else       pwm_m <= pwm_m + 3'd1;
    end

    // Waits for brightness to leave prev; reports new value, ticks elapsed, and
    // whether busy was ever low before the change.
    task automatic wait_change(input logic [2:0] prev, input int limit,
                               output logic [2:0] val, output int ticks,
                               output bit idle_seen);
        int t0;
        t0        = tick_total;
        idle_seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (brightness !== prev) break;
            if (!busy) idle_seen = 1'b1;
        end
        val   = brightness;
        ticks = tick_total - t0;
    endtask

    task automatic wait_done(input int limit, output int ticks, output bit timeout);
        int t0;
        t0      = tick_total;
        timeout = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (cycle_done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
        ticks = tick_total - t0;
    endtask

    task automatic wait_level(input logic [2:0] target, input int limit, output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (brightness === target) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int tk;
        bit to;
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (led_n !== 1'b1) begin n_fail++; $display("FAIL reset_led_n: got %b want 1", led_n); end
        n_cmp++; if (brightness !== 3'd0) begin n_fail++; $display("FAIL reset_brightness: got %0d want 0", brightness); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (cycle_done !== 1'b0) begin n_fail++; $display("FAIL reset_cycle_done: got %b want 0", cycle_done); end
        @(posedge clk);
        #1 reset = 1'b0;
        wait_done(80, tk, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL reset_first_done: no cycle_done within bound"); end
        n_cmp++; if (tk !== 8) begin n_fail++; $display("FAIL reset_done_ticks: got %0d want 8", tk); end
        n_cmp++; if (busy !== 1'b1 || brightness !== 3'd0) begin
            n_fail++; $display("FAIL reset_rise_entry: busy=%b bright=%0d want busy=1 bright=0", busy, brightness);
        end
    endtask

    // Starts just after a cycle_done pulse (RISE, brightness 0).
    task automatic test_full_cycle();
        logic [2:0] v;
        int tk;
        bit idle, to;
        for (int k = 1; k <= 7; k++) begin
            wait_change(3'(k - 1), 40, v, tk, idle);
            n_cmp++; if (v !== 3'(k)) begin n_fail++; $display("FAIL rise_level: got %0d want %0d", v, k); end
            n_cmp++; if (tk !== 2) begin n_fail++; $display("FAIL rise_ticks[%0d]: got %0d want 2", k, tk); end
            n_cmp++; if (busy !== 1'b1 || idle) begin n_fail++; $display("FAIL rise_busy[%0d]: busy=%b idle=%b want 1/0", k, busy, idle); end
        end
        // HOLD takes 3 steps, the 4th step gives the first decrement.
        for (int k = 6; k >= 0; k--) begin
            wait_change(3'(k + 1), 60, v, tk, idle);
            n_cmp++; if (v !== 3'(k)) begin n_fail++; $display("FAIL fall_level: got %0d want %0d", v, k); end
            n_cmp++; if (tk !== ((k == 6) ? 8 : 2)) begin n_fail++; $display("FAIL fall_ticks[%0d]: got %0d", k, tk); end
            n_cmp++; if (busy !== (k != 0) || idle) begin n_fail++; $display("FAIL fall_busy[%0d]: busy=%b idle=%b", k, busy, idle); end
        end
        wait_done(60, tk, to);
        n_cmp++; if (to || tk !== 8) begin n_fail++; $display("FAIL off_ticks: got %0d timeout=%b want 8", tk, to); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL off_to_rise_busy: got %b want 1", busy); end
    endtask

    task automatic test_pwm_duty();
        bit to;
        int zeros;
        logic exp_led;
        wait_level(3'd3, 100, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL pwm_reach3: brightness stuck at %0d", brightness); end
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            // pwm_m is one ahead of the value the DUT compared on this edge.
            exp_led = !((pwm_m - 3'd1) < 3'd3);
            if (led_n === 1'b0) zeros++;
            n_cmp++; if (led_n !== exp_led) begin n_fail++; $display("FAIL pwm_led_n[%0d]: got %b want %b", i, led_n, exp_led); end
        end
        n_cmp++; if (zeros !== 3) begin n_fail++; $display("FAIL pwm_duty: got %0d low cycles want 3", zeros); end
    endtask

    task automatic test_enable_drop();
        logic [2:0] v;
        int tk, tk2;
        bit to, idle, bad;
        wait_level(3'd5, 60, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL drop_reach5: brightness stuck at %0d", brightness); end
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (brightness !== 3'd5 || busy !== 1'b1) begin
            n_fail++; $display("FAIL drop_hold5: bright=%0d busy=%b want 5/1", brightness, busy);
        end
        for (int k = 4; k >= 0; k--) begin
            wait_change(3'(k + 1), 40, v, tk, idle);
            n_cmp++; if (v !== 3'(k) || tk !== 2) begin
                n_fail++; $display("FAIL drop_fall[%0d]: got %0d after %0d ticks want %0d after 2", k, v, tk, k);
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_off_busy: got %b want 0", busy); end
        // 60 clk = 15 ticks, odd, so a non-parked prescaler would shift the next cycle.
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (cycle_done !== 1'b0 || busy !== 1'b0 || brightness !== 3'd0) bad = 1'b1;
        end
        n_cmp++; if (bad) begin n_fail++; $display("FAIL drop_idle: activity while disabled in OFF"); end
        enable = 1'b1;
        wait_done(60, tk2, to);
        n_cmp++; if (to || tk2 !== 8) begin n_fail++; $display("FAIL drop_restart_ticks: got %0d timeout=%b want 8", tk2, to); end
    endtask

    task automatic test_reenable_fall();
        logic [2:0] v;
        int tk;
        bit to, idle;
        wait_level(3'd2, 60, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL refall_reach2: brightness stuck at %0d", brightness); end
        enable = 1'b0;
        wait_change(3'd2, 40, v, tk, idle);
        n_cmp++; if (v !== 3'd1 || tk !== 2) begin n_fail++; $display("FAIL refall_to1: got %0d after %0d ticks want 1 after 2", v, tk); end
        enable = 1'b1;
        wait_change(3'd1, 40, v, tk, idle);
        n_cmp++; if (v !== 3'd0 || tk !== 2) begin n_fail++; $display("FAIL refall_to0: got %0d after %0d ticks want 0 after 2", v, tk); end
        n_cmp++; if (busy !== 1'b0 || idle) begin n_fail++; $display("FAIL refall_busy: busy=%b idle=%b want 0/0", busy, idle); end
        wait_done(60, tk, to);
        n_cmp++; if (to || tk !== 8) begin n_fail++; $display("FAIL refall_off_ticks: got %0d timeout=%b want 8", tk, to); end
        wait_change(3'd0, 40, v, tk, idle);
        n_cmp++; if (v !== 3'd1 || tk !== 2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL refall_rise: got %0d after %0d ticks busy=%b want 1/2/1", v, tk, busy);
        end
    endtask

    task automatic test_async_reset();
        int tk;
        bit to, low_seen;
        wait_level(3'd7, 200, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL areset_reach7: brightness stuck at %0d", brightness); end
        low_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led_n === 1'b0) begin
                low_seen = 1'b1;
                break;
            end
        end
        n_cmp++; if (!low_seen) begin n_fail++; $display("FAIL areset_led_low: led_n never low in HOLD"); end
        // Assert between edges; outputs must clear before the next rising edge.
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (led_n !== 1'b1) begin n_fail++; $display("FAIL areset_led_n: got %b want 1", led_n); end
        n_cmp++; if (brightness !== 3'd0) begin n_fail++; $display("FAIL areset_brightness: got %0d want 0", brightness); end
        n_cmp++; if (busy !== 1'b0 || cycle_done !== 1'b0) begin
            n_fail++; $display("FAIL areset_flags: busy=%b done=%b want 0/0", busy, cycle_done);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        wait_done(80, tk, to);
        n_cmp++; if (to || tk !== 8) begin n_fail++; $display("FAIL areset_restart_ticks: got %0d timeout=%b want 8", tk, to); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        enable = 1'b1;
        test_reset();
        test_full_cycle();
        test_pwm_duty();
        test_enable_drop();
        test_reenable_fall();
        test_async_reset();
        test_pwm_duty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
